// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types and helpers for the stochastic-computing multiplier
// Contents:
//   sc_state_t : controller states IDLE / RUN / DONE
//   SC_LEN(w)  : bitstream length 2**w for a w-bit operand
//   sc_sat     : clamp a (w+1)-bit ones count to the w-bit maximum
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_state_t;

  function automatic longint unsigned SC_LEN(input int w);
    return 64'd1 << w;
  endfunction

  // Works on the widest supported count (32-bit operands, 33-bit count);
  // callers cast the result down to their own width.
  function automatic logic [32:0] sc_sat(input logic [32:0] ones, input int w);
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    return (ones > lim) ? lim : ones;
  endfunction

endpackage

// File: rtl/sc_sng.sv
// rtl/sc_sng.sv - stochastic number generator (unipolar comparator)
// Ports:
//   rnd in  WIDTH : random word for this cycle
//   x   in  WIDTH : operand value
//   s   out 1     : stream bit, 1 when rnd < x (unsigned)
module sc_sng #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rnd,
  input  logic [WIDTH-1:0] x,
  output logic             s
);

  assign s = (rnd < x);

endmodule

// File: rtl/sc_mult_core.sv
// rtl/sc_mult_core.sv - stochastic-computing multiplier, product ~ a*b/2^WIDTH
// Optional feature macro: SC_MULT_ABORT_EN (adds the abort input)
// Ports:
//   clk     in  1     : rising-edge clock
//   reset   in  1     : asynchronous active-low reset
//   start   in  1     : run request, accepted only when idle
//   a, b    in  WIDTH : operands, captured on the accepted start
//   rnd1/2  in  WIDTH : per-cycle random words for the A and B streams
//   abort   in  1     : (SC_MULT_ABORT_EN only) cancel a run in progress
//   busy    out 1     : high from the cycle after start through the done cycle
//   done    out 1     : one-cycle pulse, product valid
//   product out WIDTH : saturated ones count, held until the next start
module sc_mult_core
  import sc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] rnd1,
  input  logic [WIDTH-1:0] rnd2,
`ifdef SC_MULT_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  // cyc value of the final sample in a run of 2^WIDTH samples
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(SC_LEN(WIDTH) - 64'd1);

  sc_state_t        state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   ones, cyc;
  logic             sa, sb;
  logic             abort_hit;

`ifdef SC_MULT_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  sc_sng #(.WIDTH(WIDTH)) u_sng_a (.rnd(rnd1), .x(a_q), .s(sa));
  sc_sng #(.WIDTH(WIDTH)) u_sng_b (.rnd(rnd2), .x(b_q), .s(sb));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ones    <= '0;
      cyc     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high during the done cycle, which blocks a start there
          if (start && !busy) begin
            a_q   <= a;
            b_q   <= b;
            ones  <= '0;
            cyc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (abort_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ones <= ones + {{WIDTH{1'b0}}, sa & sb};
            cyc  <= cyc + 1'b1;
            if (cyc == LAST) state <= DONE;
          end
        end
        DONE: begin
          if (abort_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            product <= WIDTH'(sc_sat(33'(ones), WIDTH));
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_mult_core.sv
// tb/tb_sc_mult_core.sv - self-checking bench for sc_mult_core (WIDTH=8)
module tb_sc_mult_core;

  localparam int W = 8;
  localparam int N = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] rnd1 = '0;
  logic [W-1:0] rnd2 = '0;
`ifdef SC_MULT_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] product;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] r1 [N];
  logic [W-1:0] r2 [N];

  always #5 clk = ~clk;

  sc_mult_core #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .rnd1    (rnd1),
    .rnd2    (rnd2),
`ifdef SC_MULT_ABORT_EN
    .abort   (abort),
`endif
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = v[W-1-k];
    return r;
  endfunction

  // Reference: count the cycles where both unipolar streams are 1, clamp to 2^W-1.
  function automatic int ref_product(input logic [W-1:0] av, input logic [W-1:0] bv);
    int cnt;
    cnt = 0;
    for (int k = 0; k < N; k++)
      if ((int'(r1[k]) < int'(av)) && (int'(r2[k]) < int'(bv))) cnt++;
    return (cnt > N - 1) ? N - 1 : cnt;
  endfunction

  // mode 0: rnd1=rnd2=i, mode 1: rnd1=i, rnd2=bitrev(i), else random
  task automatic gen(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: begin r1[k] = W'(k); r2[k] = W'(k); end
        1: begin r1[k] = W'(k); r2[k] = bitrev(W'(k)); end
        default: begin r1[k] = W'($urandom); r2[k] = W'($urandom); end
      endcase
    end
  endtask

  // One complete run starting at a negedge; ends at a negedge one cycle after done.
  task automatic run(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input bit mid_start, input bit change_a);
    int expv, n, dones;
    expv  = ref_product(av, bv);
    dones = 0;
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    for (int i = 0; i < N; i++) begin
      rnd1  = r1[i];
      rnd2  = r2[i];
      start = mid_start && (i == 100);
      if (change_a && i == 60) a = ~av;
      @(negedge clk);
      if (done) dones++;
    end
    start = mid_start;
    rnd1  = W'($urandom);
    rnd2  = W'($urandom);
    n = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(N + n), 32'(N + 1));
    chk({tag, "_product"}, 32'(product), 32'(expv));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_product_hold"}, 32'(product), 32'(expv));
    chk({tag, "_early_done"}, 32'(dones), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, prev;

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    gen(0); run("t1_correlated", 8'd128, 8'd128, 1'b0, 1'b0);
    gen(1); run("t2_bitrev", 8'd128, 8'd128, 1'b0, 1'b0);
    gen(0); run("t3_b_zero", 8'd255, 8'd0, 1'b0, 1'b0);
    gen(0); run("t3_full", 8'd255, 8'd255, 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      gen(2);
      run($sformatf("rand%0d", t), ra, rb, 1'b0, 1'b0);
    end
    gen(2); run("a_zero", 8'd0, W'($urandom), 1'b0, 1'b0);

    gen(2); run("t5_ignore_start", W'($urandom_range(40, 250)), W'($urandom_range(40, 250)), 1'b1, 1'b1);

    // Reset in the middle of a run
    gen(2);
    a = 8'd200; b = 8'd220; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rnd1 = r1[i]; rnd2 = r2[i];
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("t4_reset_busy", 32'(busy), 32'd0);
    chk("t4_reset_product", 32'(product), 32'd0);
    @(negedge clk);
    chk("t4_reset_busy_next", 32'(busy), 32'd0);
    chk("t4_reset_done_next", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    gen(2); run("t4_after_reset", W'($urandom), W'($urandom), 1'b0, 1'b0);

`ifdef SC_MULT_ABORT_EN
    begin
      int dcnt;
      prev = product;
      gen(2);
      a = 8'd200; b = 8'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
        rnd1 = r1[i]; rnd2 = r2[i];
        @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t6_abort_busy", 32'(busy), 32'd0);
      dcnt = 0;
      for (int i = 0; i < 300; i++) begin
        rnd1 = W'($urandom); rnd2 = W'($urandom);
        @(negedge clk);
        if (done) dcnt++;
      end
      chk("t6_abort_no_done", 32'(dcnt), 32'd0);
      chk("t6_abort_product", 32'(product), 32'(prev));
      gen(2); run("t6_after_abort", 8'd128, 8'd128, 1'b0, 1'b0);
    end
`else
    prev = product;
    chk("final_product_hold", 32'(product), 32'(prev));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
